imem_loader: RTL and testbench

Boot-time program loader that writes instruction words into the processor's instruction memory. Bytes arrive from an upstream serial receiver over a valid/ready stream and are framed, assembled into little-endian 32-bit words, and written sequentially from word address 0. The processor is held in reset until a complete image has been written. Sits between the UART receiver and the instruction RAM write port; the instruction RAM read side is unchanged.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/loader_timeout.sv | 29 ++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // Frame layout
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned LANE_W = 2;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [LANE_W-1:0] LAST_LANE = 2'd3;

  // True while a frame is in progress and the inter-byte timeout applies
  function automatic logic in_frame(input state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Saturating inter-byte cycle counter; expire_c flags TIMEOUT_CYC idle cycles.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  // Count idle cycles, holding at the limit until cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_loader.sv
// Frames a byte stream into little-endian words and writes them to instruction RAM.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;

  logic [BYTE_W-1:0]       len_lo_q;
  logic [ADDR_W-1:0]       len_m1_q;
  logic [ADDR_W-1:0]       widx_q;
  logic [LANE_W-1:0]       lane_q;
  logic [WORD_W-BYTE_W-1:0] wbuf_q;

  logic             acc_c;
  logic             tmo_clear_c;
  logic             tmo_expire_c;
  logic [LEN_W-1:0] len_c;
  logic             last_word_c;
  logic             at_rest_c;

  // Byte handshake and frame-field decode
  assign rx_ready    = (state_q == ST_IDLE) || in_frame(state_q);
  assign acc_c       = rx_valid && rx_ready;
  assign len_c       = {rx_data, len_lo_q};
  assign last_word_c = (widx_q == len_m1_q);
  assign at_rest_c   = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign tmo_clear_c = acc_c || !in_frame(state_q);

  loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (tmo_clear_c),
    .expire_c (tmo_expire_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an accepted byte wins over timeout expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_c && (rx_data == SYNC_BYTE)) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (acc_c)             state_d = ST_LEN_HI;
        else if (tmo_expire_c) state_d = ST_ERR;
      end
      ST_LEN_HI: begin
        if (acc_c) begin
          if (len_c == '0)               state_d = ST_DONE;
          else if (32'(len_c) > DEPTH)   state_d = ST_ERR;
          else                           state_d = ST_DATA;
        end else if (tmo_expire_c) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        if (acc_c) begin
          if ((lane_q == LAST_LANE) && last_word_c) state_d = ST_DONE;
        end else if (tmo_expire_c) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (rearm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_lo_q  <= '0;
      len_m1_q  <= '0;
      widx_q    <= '0;
      lane_q    <= '0;
      wbuf_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (acc_c && (state_q == ST_LEN_LO)) begin
        len_lo_q <= rx_data;
      end

      if (acc_c && (state_q == ST_LEN_HI)) begin
        len_m1_q <= ADDR_W'(len_c - 16'd1);
        widx_q   <= '0;
        lane_q   <= '0;
      end

      if (acc_c && (state_q == ST_DATA)) begin
        lane_q <= lane_q + LANE_W'(1);
        case (lane_q)
          2'd0: wbuf_q[7:0]   <= rx_data;
          2'd1: wbuf_q[15:8]  <= rx_data;
          2'd2: wbuf_q[23:16] <= rx_data;
          default: begin
            mem_we    <= 1'b1;
            mem_addr  <= widx_q;
            mem_wdata <= {rx_data, wbuf_q};
            widx_q    <= widx_q + ADDR_W'(1);
          end
        endcase
      end

      if (rearm && at_rest_c) begin
        widx_q <= '0;
        lane_q <= '0;
      end

      // cpu_hold falls one cycle after DONE is entered, after the last write
      cpu_hold <= !((state_q == ST_DONE) && !rearm);
      done     <= (state_d == ST_DONE);
      error    <= (state_d == ST_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, endianness, length limits, timeout, reset.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 16;

  logic              clk;
  logic              reset_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rearm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [63:0] wr_q[$];
  int          wr_cyc[$];

  imem_loader #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rearm     (rearm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({24'h0, mem_addr, mem_wdata});
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for one cycle; a ready loader takes it on that edge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    step();
    rearm = 1'b0;
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  initial begin
    int k;
    logic [7:0] f1[11];
    logic [7:0] f2[9];

    f1 = '{8'hA5, 8'h02, 8'h00, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'hFF, 8'h20, 8'h80, 8'hE2};
    f2 = '{8'h00, 8'h13, 8'hA5, 8'h01, 8'h00, 8'h04, 8'h28, 8'h80, 8'hE5};

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rearm    = 1'b0;
    repeat (3) step();

    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_hold",  64'(cpu_hold),  64'd1);
    check("rst_done",      64'(done),      64'd0);
    check("rst_error",     64'(error),     64'd0);
    check("rst_rx_ready",  64'(rx_ready),  64'd1);
    reset_n = 1'b1;
    step();

    // Two-word frame, bytes back to back
    clear_log();
    for (int i = 0; i < 11; i++) send(f1[i]);
    check("t1_we_last",    64'(mem_we),    64'd1);
    check("t1_addr_last",  64'(mem_addr),  64'd1);
    check("t1_wdata_last", 64'(mem_wdata), 64'hE28020FF);
    check("t1_done",       64'(done),      64'd1);
    check("t1_hold_same",  64'(cpu_hold),  64'd1);
    check("t1_ready_done", 64'(rx_ready),  64'd0);
    step();
    check("t1_hold_fall",  64'(cpu_hold),  64'd0);
    check("t1_we_pulse",   64'(mem_we),    64'd0);
    check("t1_nwrites",    64'(wr_q.size()), 64'd2);
    if (wr_q.size() >= 2) begin
      check("t1_w0", wr_q[0], {24'h0, 8'h00, 32'hE04F000F});
      check("t1_w1", wr_q[1], {24'h0, 8'h01, 32'hE28020FF});
      check("t1_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
    end

    // Rearm, then leading junk before the sync byte
    pulse_rearm();
    check("t2_rearm_done", 64'(done),     64'd0);
    check("t2_rearm_hold", 64'(cpu_hold), 64'd1);
    check("t2_rearm_rdy",  64'(rx_ready), 64'd1);
    clear_log();
    for (int i = 0; i < 9; i++) send(f2[i]);
    step();
    check("t2_nwrites", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() >= 1) check("t2_w0", wr_q[0], {24'h0, 8'h00, 32'hE5802804});
    check("t2_done", 64'(done), 64'd1);

    // Zero-length frame
    pulse_rearm();
    clear_log();
    send(8'hA5); send(8'h00); send(8'h00);
    check("t3_done", 64'(done), 64'd1);
    step(); step();
    check("t3_nwrites", 64'(wr_q.size()), 64'd0);
    check("t3_hold",    64'(cpu_hold),    64'd0);

    // Oversize length (257 words)
    pulse_rearm();
    clear_log();
    send(8'hA5); send(8'h01); send(8'h01);
    check("t4_error", 64'(error),    64'd1);
    check("t4_ready", 64'(rx_ready), 64'd0);
    check("t4_hold",  64'(cpu_hold), 64'd1);
    check("t4_done",  64'(done),     64'd0);
    step();
    check("t4_nwrites", 64'(wr_q.size()), 64'd0);

    // Stall mid-word until the inter-byte timeout fires
    pulse_rearm();
    clear_log();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    k = 0;
    while (!error && k < int'(TMO) + 10) begin
      step();
      k++;
    end
    check("t5_tmo_cycles", 64'(k),     64'(TMO + 1));
    check("t5_error",      64'(error), 64'd1);
    check("t5_nwrites",    64'(wr_q.size()), 64'd1);
    if (wr_q.size() >= 1) check("t5_w0", wr_q[0], {24'h0, 8'h00, 32'h44332211});
    pulse_rearm();
    check("t5_rearm_err",  64'(error),    64'd0);
    check("t5_rearm_hold", 64'(cpu_hold), 64'd1);
    check("t5_rearm_rdy",  64'(rx_ready), 64'd1);

    // Reset in the middle of a word, then a fresh one-word frame
    clear_log();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC);
    reset_n = 1'b0;
    #1;
    check("t6_rst_hold", 64'(cpu_hold), 64'd1);
    check("t6_rst_we",   64'(mem_we),   64'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    step();
    check("t6_nwrites", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() >= 1) check("t6_w0", wr_q[0], {24'h0, 8'h00, 32'hEFBEADDE});
    check("t6_done", 64'(done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
